me_stream_bridge: RTL and testbench

ME_STREAM_BRIDGE -- requirements
Module: me_stream_bridge

---
 rtl/me_pkg.sv | 30 +++
 rtl/me_word_buf.sv | 32 +++
 rtl/me_stream_bridge.sv | 175 +++++++++++++++++
 tb/tb_me_stream_bridge.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared definitions for the modular-exponentiation stream bridge.
//   me_state_e  - bridge FSM states
//   MeDefaultK  - default word width in bits
//   MeDefaultN  - default number of words per operand
//   clog2()     - ceiling log2, used to size word indices
package me_pkg;

  localparam int unsigned MeDefaultK = 128;
  localparam int unsigned MeDefaultN = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } me_state_e;

  // Returns 0 for values 0 and 1 so a single-word build still gets a legal index width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/me_word_buf.sv
// me_word_buf: N x K word buffer with one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk    in   clock (rising edge)
//   we     in   write enable
//   waddr  in   AW-bit write index
//   wdata  in   K-bit write data
//   raddr  in   AW-bit read index
//   rdata  out  K-bit word at raddr (combinational)
module me_word_buf #(
  parameter int unsigned K  = 128,
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/me_stream_bridge.sv
// me_stream_bridge: loads an N-word operand from a stream, hands it to a
// modular-exponentiation core, collects the N-word result and streams it out.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   me_start       in   one-cycle pulse, begins operand load
//   me_abort       in   cancels any operation, returns to idle
//   me_x/_valid    in   operand word stream (LSW first), me_x_ready out
//   core_start     out  one-cycle pulse on the first RUN cycle
//   core_x_addr    in   core read index, core_x_word out (combinational)
//   core_y_word/_valid in  result word stream from core (LSW first)
//   me_result/_valid   out result word stream, me_ready in
//   me_busy        out  high in any state but idle
//   me_done        out  one-cycle pulse when the last result word has transferred
//   me_err         out  sticky protocol-error flag
module me_stream_bridge
  import me_pkg::*;
#(
  parameter int unsigned K  = MeDefaultK,
  parameter int unsigned N  = MeDefaultN,
  parameter int unsigned AW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          me_start,
  input  logic          me_abort,
  input  logic [K-1:0]  me_x,
  input  logic          me_x_valid,
  output logic          me_x_ready,
  output logic          core_start,
  input  logic [AW-1:0] core_x_addr,
  output logic [K-1:0]  core_x_word,
  input  logic [K-1:0]  core_y_word,
  input  logic          core_y_valid,
  output logic [K-1:0]  me_result,
  output logic          me_valid,
  input  logic          me_ready,
  output logic          me_busy,
  output logic          me_done,
  output logic          me_err
);

  localparam int unsigned LastIdxInt = N - 1;
  localparam logic [AW:0] LastIdx    = LastIdxInt[AW:0];

  me_state_e   state_q;
  logic [AW:0] cnt_q;
  logic        core_start_q;
  logic        me_done_q;
  logic        me_err_q;

  logic last_word;
  logic x_we;
  logic y_we;
  logic start_ok;
  logic err_evt;

  assign last_word = (cnt_q == LastIdx);

  // Buffer writes are suppressed on an abort cycle so nothing of a cancelled
  // operation lands after the cancel.
  assign x_we = (state_q == StLoad) && me_x_valid && !me_abort;
  assign y_we = (state_q == StRun) && core_y_valid && !me_abort;

  assign start_ok = (state_q == StIdle) && me_start && !me_abort;

  assign err_evt = (me_start && (state_q != StIdle)) ||
                   (me_x_valid && (state_q != StLoad)) ||
                   (core_y_valid && (state_q != StRun));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      me_done_q    <= 1'b0;
      me_err_q     <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      me_done_q    <= 1'b0;

      // An accepted start clears the flag, but an error seen in the same
      // cycle still wins.
      if (err_evt) begin
        me_err_q <= 1'b1;
      end else if (start_ok) begin
        me_err_q <= 1'b0;
      end

      if (me_abort) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (me_start) begin
              state_q <= StLoad;
              cnt_q   <= '0;
            end
          end
          StLoad: begin
            if (me_x_valid) begin
              if (last_word) begin
                state_q      <= StRun;
                cnt_q        <= '0;
                core_start_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StRun: begin
            if (core_y_valid) begin
              if (last_word) begin
                state_q <= StDrain;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StDrain: begin
            if (me_ready) begin
              if (last_word) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                me_done_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Operand buffer is written only in LOAD, so it stays frozen for the core
  // through RUN and DRAIN.
  me_word_buf #(
    .K  (K),
    .N  (N),
    .AW (AW)
  ) u_op_buf (
    .clk   (clk),
    .we    (x_we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (me_x),
    .raddr (core_x_addr),
    .rdata (core_x_word)
  );

  me_word_buf #(
    .K  (K),
    .N  (N),
    .AW (AW)
  ) u_res_buf (
    .clk   (clk),
    .we    (y_we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (core_y_word),
    .raddr (cnt_q[AW-1:0]),
    .rdata (me_result)
  );

  assign me_x_ready = (state_q == StLoad);
  assign me_busy    = (state_q != StIdle);
  assign me_valid   = (state_q == StDrain);
  assign core_start = core_start_q;
  assign me_done    = me_done_q;
  assign me_err     = me_err_q;

endmodule

// File: tb/tb_me_stream_bridge.sv
// Testbench for me_stream_bridge: randomized operands and handshakes, an
// echoing core model, and a queue-based reference of the expected results.
module tb_me_stream_bridge;

  localparam int unsigned K   = 128;
  localparam int unsigned N   = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned K2  = 64;
  localparam int unsigned N2  = 32;
  localparam int unsigned AW2 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          me_start = 1'b0, me_abort = 1'b0, me_x_valid = 1'b0;
  logic [K-1:0]  me_x = '0;
  logic          me_x_ready, core_start;
  logic [AW-1:0] core_x_addr = '0;
  logic [K-1:0]  core_x_word;
  logic [K-1:0]  core_y_word = '0;
  logic          core_y_valid = 1'b0;
  logic [K-1:0]  me_result;
  logic          me_valid, me_busy, me_done, me_err;
  logic          me_ready = 1'b0;

  logic           w_start = 1'b0, w_abort = 1'b0, w_x_valid = 1'b0;
  logic [K2-1:0]  w_x = '0;
  logic           w_x_ready, w_core_start;
  logic [AW2-1:0] w_core_x_addr = '0;
  logic [K2-1:0]  w_core_x_word;
  logic [K2-1:0]  w_core_y_word = '0;
  logic           w_core_y_valid = 1'b0;
  logic [K2-1:0]  w_result;
  logic           w_valid, w_busy, w_done, w_err;
  logic           w_ready = 1'b0;

  me_stream_bridge u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .me_start     (me_start),
    .me_abort     (me_abort),
    .me_x         (me_x),
    .me_x_valid   (me_x_valid),
    .me_x_ready   (me_x_ready),
    .core_start   (core_start),
    .core_x_addr  (core_x_addr),
    .core_x_word  (core_x_word),
    .core_y_word  (core_y_word),
    .core_y_valid (core_y_valid),
    .me_result    (me_result),
    .me_valid     (me_valid),
    .me_ready     (me_ready),
    .me_busy      (me_busy),
    .me_done      (me_done),
    .me_err       (me_err)
  );

  me_stream_bridge #(
    .K (K2),
    .N (N2)
  ) u_dut_wide (
    .clk          (clk),
    .rst_n        (rst_n),
    .me_start     (w_start),
    .me_abort     (w_abort),
    .me_x         (w_x),
    .me_x_valid   (w_x_valid),
    .me_x_ready   (w_x_ready),
    .core_start   (w_core_start),
    .core_x_addr  (w_core_x_addr),
    .core_x_word  (w_core_x_word),
    .core_y_word  (w_core_y_word),
    .core_y_valid (w_core_y_valid),
    .me_result    (w_result),
    .me_valid     (w_valid),
    .me_ready     (w_ready),
    .me_busy      (w_busy),
    .me_done      (w_done),
    .me_err       (w_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cs_cnt   = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (core_start) cs_cnt <= cs_cnt + 1;
    if (me_done) done_cnt <= done_cnt + 1;
  end

  logic [K-1:0] op_words[$];
  logic [K-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the echo core returns the operand unchanged, so the expected
  // result stream is the operand words in order.
  task automatic gen_ops(input bit counting);
    op_words.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      logic [K-1:0] w;
      w = counting ? K'(i + 1) : {$urandom, $urandom, $urandom, $urandom};
      op_words.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic do_start();
    me_start = 1'b1;
    tick();
    me_start = 1'b0;
  endtask

  task automatic send_ops(input int n_beats, input bit gaps);
    for (int i = 0; i < n_beats; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      me_x       = op_words[i];
      me_x_valid = 1'b1;
      tick();
      me_x_valid = 1'b0;
    end
  endtask

  // Core model: reads each operand word through the combinational port and
  // echoes it back as the result word.
  task automatic run_core(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      core_x_addr = AW'(i);
      #1;
      core_y_word  = core_x_word;
      core_y_valid = 1'b1;
      tick();
      core_y_valid = 1'b0;
    end
  endtask

  // mode 0: ready always high, 1: toggling, 2: random. Returns after stop_at
  // transfers, one cycle past the last transfer edge.
  task automatic drain_and_check(input int mode, input int stop_at);
    int n_xfer = 0;
    int cycles = 0;
    logic prev_stall = 1'b0;
    logic [K-1:0] prev_res = '0;
    logic [K-1:0] want;
    while (n_xfer < stop_at && cycles < 8 * N) begin
      case (mode)
        0:       me_ready = 1'b1;
        1:       me_ready = (cycles % 2 == 0);
        default: me_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ({me_valid, me_result} !== {1'b1, prev_res})
          $display("FAIL drain_hold: got valid=%b %h want valid=1 %h", me_valid, me_result,
                   prev_res);
        else n_pass++;
      end
      if (me_valid && me_ready) begin
        want = exp_q.pop_front();
        n_checks++;
        if (me_result !== want)
          $display("FAIL drain_word[%0d]: got %h want %h", n_xfer, me_result, want);
        else n_pass++;
        n_xfer++;
      end
      prev_stall = me_valid && !me_ready;
      prev_res   = me_result;
      cycles++;
      @(posedge clk);
      #1;
    end
    me_ready = 1'b0;
    if (n_xfer < stop_at) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d transfers want %0d", n_xfer, stop_at);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({me_x_ready, core_start, me_valid, me_busy, me_done, me_err} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {me_x_ready, core_start, me_valid, me_busy, me_done, me_err});
    else n_pass++;
    n_checks++;
    if ({w_x_ready, w_core_start, w_valid, w_busy, w_done, w_err} !== 6'b0)
      $display("FAIL reset_outputs_wide: got %b want 000000",
               {w_x_ready, w_core_start, w_valid, w_busy, w_done, w_err});
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (me_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", me_busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cs0 = cs_cnt;
    int d0  = done_cnt;
    gen_ops(1'b1);
    do_start();
    n_checks++;
    if ({me_x_ready, me_busy, me_err} !== 3'b110)
      $display("FAIL basic_load_entry: got %b want 110", {me_x_ready, me_busy, me_err});
    else n_pass++;
    send_ops(N, 1'b0);
    n_checks++;
    if ({core_start, me_x_ready} !== 2'b10)
      $display("FAIL basic_core_start: got %b want 10", {core_start, me_x_ready});
    else n_pass++;
    run_core(1'b0);
    n_checks++;
    if (me_valid !== 1'b1) $display("FAIL basic_first_valid: got %b want 1", me_valid);
    else n_pass++;
    drain_and_check(0, N);
    n_checks++;
    if ({me_done, me_busy, me_valid} !== 3'b100)
      $display("FAIL basic_done: got %b want 100", {me_done, me_busy, me_valid});
    else n_pass++;
    tick();
    n_checks++;
    if ({me_done, me_err} !== 2'b00 || done_cnt - d0 != 1 || cs_cnt - cs0 != 1)
      $display("FAIL basic_counts: got done=%b err=%b dones=%0d starts=%0d want 0 0 1 1",
               me_done, me_err, done_cnt - d0, cs_cnt - cs0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int d0 = done_cnt;
    gen_ops(1'b0);
    do_start();
    send_ops(N, 1'b1);
    run_core(1'b1);
    drain_and_check(1, N);
    tick();
    n_checks++;
    if (done_cnt - d0 != 1 || me_err !== 1'b0)
      $display("FAIL stall_done: got dones=%0d err=%b want 1 0", done_cnt - d0, me_err);
    else n_pass++;
  endtask

  task automatic test_extra_beat();
    int cs0 = cs_cnt;
    gen_ops(1'b0);
    do_start();
    send_ops(N, 1'b0);
    n_checks++;
    if (core_start !== 1'b1) $display("FAIL extra_core_start: got %b want 1", core_start);
    else n_pass++;
    me_x       = '0;
    me_x_valid = 1'b1;
    tick();
    me_x_valid = 1'b0;
    n_checks++;
    if ({me_err, core_start} !== 2'b10)
      $display("FAIL extra_err: got %b want 10", {me_err, core_start});
    else n_pass++;
    run_core(1'b0);
    drain_and_check(2, N);
    tick();
    n_checks++;
    if (cs_cnt - cs0 != 1 || me_err !== 1'b1)
      $display("FAIL extra_counts: got starts=%0d err=%b want 1 1", cs_cnt - cs0, me_err);
    else n_pass++;
  endtask

  task automatic test_abort_load();
    int cs0 = cs_cnt;
    int d0  = done_cnt;
    gen_ops(1'b0);
    do_start();
    n_checks++;
    if (me_err !== 1'b0) $display("FAIL abort_err_cleared: got %b want 0", me_err);
    else n_pass++;
    send_ops(8, 1'b0);
    me_x       = op_words[8];
    me_x_valid = 1'b1;
    me_abort   = 1'b1;
    tick();
    me_x_valid = 1'b0;
    me_abort   = 1'b0;
    n_checks++;
    if ({me_busy, me_x_ready, core_start, me_valid, me_err} !== 5'b0)
      $display("FAIL abort_idle: got %b want 00000",
               {me_busy, me_x_ready, core_start, me_valid, me_err});
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (cs_cnt != cs0) $display("FAIL abort_no_core_start: got %0d want 0", cs_cnt - cs0);
    else n_pass++;
    gen_ops(1'b0);
    do_start();
    send_ops(N, 1'b1);
    run_core(1'b1);
    drain_and_check(2, N);
    tick();
    n_checks++;
    if (done_cnt - d0 != 1 || cs_cnt - cs0 != 1)
      $display("FAIL abort_followup: got dones=%0d starts=%0d want 1 1", done_cnt - d0,
               cs_cnt - cs0);
    else n_pass++;
  endtask

  task automatic test_start_in_run();
    gen_ops(1'b0);
    do_start();
    send_ops(N, 1'b0);
    do_start();
    n_checks++;
    if ({me_err, me_busy, me_x_ready} !== 3'b110)
      $display("FAIL run_start_ignored: got %b want 110", {me_err, me_busy, me_x_ready});
    else n_pass++;
    run_core(1'b1);
    drain_and_check(2, N);
    tick();
    n_checks++;
    if ({me_err, me_busy} !== 2'b10)
      $display("FAIL run_err_sticky: got %b want 10", {me_err, me_busy});
    else n_pass++;
    do_start();
    n_checks++;
    if ({me_err, me_x_ready} !== 2'b01)
      $display("FAIL run_err_clear: got %b want 01", {me_err, me_x_ready});
    else n_pass++;
    me_abort = 1'b1;
    tick();
    me_abort = 1'b0;
    n_checks++;
    if (me_busy !== 1'b0) $display("FAIL run_abort_idle: got %b want 0", me_busy);
    else n_pass++;
  endtask

  task automatic test_reset_drain();
    int d0 = done_cnt;
    gen_ops(1'b0);
    do_start();
    send_ops(N, 1'b0);
    run_core(1'b0);
    drain_and_check(0, 5);
    n_checks++;
    if ({me_valid, me_result} !== {1'b1, op_words[5]})
      $display("FAIL rdrain_word5: got %b %h want 1 %h", me_valid, me_result, op_words[5]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({me_x_ready, core_start, me_valid, me_busy, me_done, me_err} !== 6'b0)
      $display("FAIL rdrain_outputs: got %b want 000000",
               {me_x_ready, core_start, me_valid, me_busy, me_done, me_err});
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (done_cnt != d0 || me_busy !== 1'b0)
      $display("FAIL rdrain_no_done: got dones=%0d busy=%b want 0 0", done_cnt - d0, me_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    for (int op = 0; op < 3; op++) begin
      gen_ops(1'b0);
      do_start();
      send_ops(N, 1'b1);
      run_core(1'b1);
      drain_and_check(2, N);
    end
    tick();
    n_checks++;
    if (done_cnt - d0 != 3 || me_err !== 1'b0)
      $display("FAIL b2b_done: got dones=%0d err=%b want 3 0", done_cnt - d0, me_err);
    else n_pass++;
  endtask

  task automatic test_wide_build();
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < N2; i++) begin
      w_x       = K2'(i + 1);
      w_x_valid = 1'b1;
      tick();
      w_x_valid = 1'b0;
    end
    n_checks++;
    if (w_core_start !== 1'b1) $display("FAIL wide_core_start: got %b want 1", w_core_start);
    else n_pass++;
    for (int i = 0; i < N2; i++) begin
      w_core_x_addr = AW2'(i);
      #1;
      w_core_y_word  = w_core_x_word;
      w_core_y_valid = 1'b1;
      tick();
      w_core_y_valid = 1'b0;
    end
    w_ready = 1'b1;
    for (int i = 0; i < N2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({w_valid, w_result} !== {1'b1, K2'(i + 1)})
        $display("FAIL wide_word[%0d]: got %b %h want 1 %h", i, w_valid, w_result, K2'(i + 1));
      else n_pass++;
      @(posedge clk);
      #1;
    end
    w_ready = 1'b0;
    n_checks++;
    if ({w_done, w_busy, w_err} !== 3'b100)
      $display("FAIL wide_done: got %b want 100", {w_done, w_busy, w_err});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_extra_beat();
    test_abort_load();
    test_start_in_run();
    test_reset_drain();
    test_back_to_back();
    test_wide_build();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
